audio_dac_serializer: RTL

//  Sink end of the effects-chain sample-strobe stream: takes (i_valid, i_data) from the last

---
 rtl/audio_pkg.sv | 6 +
 rtl/audio_sample_fifo.sv | 36 +++
 rtl/audio_dac_serializer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, sample type and DAC serializer state encoding.
package audio_pkg;
    localparam int DATA_W_DEF = 16;
    typedef logic signed [DATA_W_DEF-1:0] sample_t;
    typedef enum logic [2:0] {IDLE, LOAD, DELAY, SHIFT, PAD} dac_state_e;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous sample FIFO with wrap-flag pointers; no push-to-pop bypass.
module audio_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + LW'(1);
            if (pop_i) rd_q <= rd_q + LW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end
    assign level_o = wr_q - rd_q;
    assign full_o  = level_o == LW'(DEPTH);
    assign empty_o = wr_q == rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: FIFO-buffered I2S mono serializer framed by the codec's BCLK/DACLRCK.
// `DAC_UNDERRUN_HOLD_EN: on underrun repeat the previous sample instead of playing silence.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int I2S_DELAY  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_aud_bclk,
    input  logic                          i_aud_daclrck,
    output logic                          o_aud_dacdat,
    output logic                          o_overflow,
    output logic                          o_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int CW = $clog2(I2S_DELAY + 1) + 1;

    logic [2:0] bclk_q, lr_q;
    logic bclk_fall, lr_fall, lr_rise;
    dac_state_e state_q, state_d;
    logic [DATA_W-1:0] held_q, held_d, sh_q, sh_d, src, ur_word, fifo_dout;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d, bits;
    logic [CW-1:0] delay_cnt_q, delay_cnt_d;
    logic dac_q, dac_d, ovf_q, ur_q, start, emit;
    logic push, pop, full, empty;

    audio_sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push_i  (push),
        .data_i  (i_data),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .level_o (o_fifo_level)
    );

    assign bclk_fall = bclk_q[2] & ~bclk_q[1];
    assign lr_fall   = lr_q[2] & ~lr_q[1];
    assign lr_rise   = ~lr_q[2] & lr_q[1];

    // A pop frees a slot, so a push arriving in the LOAD cycle is accepted even when full.
    assign pop  = (state_q == LOAD) && !empty;
    assign push = i_valid && (!full || pop);

`ifdef DAC_UNDERRUN_HOLD_EN
    assign ur_word = held_q;
`else
    assign ur_word = '0;
`endif

    assign held_d = (state_q == LOAD) ? (pop ? fifo_dout : ur_word) : held_q;
    assign start  = (state_q == LOAD) || (!lr_fall && lr_rise && state_q inside {DELAY, SHIFT, PAD});
    assign emit   = start ? (I2S_DELAY == 0)
                  : (!lr_fall && bclk_fall && ((state_q == DELAY && delay_cnt_q == CW'(1)) ||
                                               (state_q == SHIFT && bit_cnt_q != '0)));
    assign src    = start ? held_d : sh_q;
    assign bits   = start ? BW'(DATA_W) : bit_cnt_q;

    // The LRCK edge coincides with a BCLK fall, which counts as the first delay slot.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        delay_cnt_d = delay_cnt_q;
        dac_d       = dac_q;
        if (emit) begin
            state_d   = SHIFT;
            dac_d     = src[DATA_W-1];
            sh_d      = src << 1;
            bit_cnt_d = bits - BW'(1);
        end else if (start) begin
            state_d     = DELAY;
            dac_d       = 1'b0;
            sh_d        = held_d;
            bit_cnt_d   = BW'(DATA_W);
            delay_cnt_d = CW'(I2S_DELAY);
        end else if (lr_fall) begin
            state_d = LOAD;
            dac_d   = 1'b0;
        end else if (bclk_fall && state_q == DELAY) begin
            delay_cnt_d = delay_cnt_q - CW'(1);
        end else if (bclk_fall && state_q == SHIFT) begin
            state_d = PAD;
            dac_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_q      <= '0;
            lr_q        <= '0;
            state_q     <= IDLE;
            held_q      <= '0;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            delay_cnt_q <= '0;
            dac_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ur_q        <= 1'b0;
        end else begin
            bclk_q      <= {bclk_q[1:0], i_aud_bclk};
            lr_q        <= {lr_q[1:0], i_aud_daclrck};
            state_q     <= state_d;
            held_q      <= held_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            dac_q       <= dac_d;
            ovf_q       <= i_valid && full && !pop;
            ur_q        <= (state_q == LOAD) && empty;
        end
    end

    assign o_aud_dacdat = dac_q;
    assign o_overflow   = ovf_q;
    assign o_underrun   = ur_q;
endmodule
